// File: rtl/drv_btn_mc.sv
// drv_btn_mc - multi-channel push-button driver.
//
// Each of NR_CH raw button inputs is synchronised (2 flops), debounced and
// classified. A press is reported as srv_o, then either short_o on release
// or long_o once held for LONG_CYC cycles, followed by periodic rep_o
// pulses while still held. All outputs are registered.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   enable_i  in   0 forces every channel back to IDLE on the next edge
//   btn_i     in   [NR_CH] raw asynchronous button levels
//   srv_o     out  [NR_CH] pulse on accepted press
//   short_o   out  [NR_CH] pulse on release of a press that never went long
//   long_o    out  [NR_CH] pulse when a press becomes long
//   rep_o     out  [NR_CH] auto-repeat pulses while long-held (REP_EN=1)
//   held_o    out  [NR_CH] level, 1 in HELD, LONG or DEB_R
//
// state  | meaning
// IDLE   | button released, waiting for synchronised high
// DEB_P  | counting stable high samples before accepting a press
// HELD   | press accepted, counting towards long press
// LONG   | long press, counting auto-repeat period
// DEB_R  | counting stable low samples before accepting a release

module drv_btn_mc #(
  parameter int NR_CH    = 4,
  parameter int DEB_CYC  = 4,
  parameter int LONG_CYC = 20,
  parameter int REP_CYC  = 8,
  parameter bit REP_EN   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [NR_CH-1:0] btn_i,
  output logic [NR_CH-1:0] srv_o,
  output logic [NR_CH-1:0] short_o,
  output logic [NR_CH-1:0] long_o,
  output logic [NR_CH-1:0] rep_o,
  output logic [NR_CH-1:0] held_o
);

  localparam int HC_MAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int HC_W   = $clog2(HC_MAX) + 1;
  localparam int DC_W   = $clog2(DEB_CYC) + 1;

  localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYC - 1);
  localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
  localparam logic [HC_W-1:0] HC_LONG = HC_W'(LONG_CYC - 1);
  localparam logic [HC_W-1:0] HC_REP  = HC_W'(REP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEB_P = 3'd1,
    ST_HELD  = 3'd2,
    ST_LONG  = 3'd3,
    ST_DEB_R = 3'd4
  } state_e;

  // Synchroniser keeps running while disabled so that re-enabling with a
  // button already down sees the true level immediately.
  logic [NR_CH-1:0] sync1_q, sync1_d;
  logic [NR_CH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar g = 0; g < NR_CH; g++) begin : g_ch
    state_e          state_q, state_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic            lg_q, lg_d;
    logic            srv_q, srv_d;
    logic            short_q, short_d;
    logic            long_q, long_d;
    logic            rep_q, rep_d;
    logic            held_q, held_d;
    logic            s;

    assign s = sync2_q[g];

    always_comb begin
      state_d = state_q;
      dc_d    = dc_q;
      hc_d    = hc_q;
      lg_d    = lg_q;
      srv_d   = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;

      if (!enable_i) begin
        state_d = ST_IDLE;
        dc_d    = '0;
        hc_d    = '0;
        lg_d    = 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (s) begin
              state_d = ST_DEB_P;
              dc_d    = DC_ONE;
            end
          end
          ST_DEB_P: begin
            if (!s) begin
              state_d = ST_IDLE;
            end else if (dc_q == DC_LAST) begin
              state_d = ST_HELD;
              srv_d   = 1'b1;
              hc_d    = '0;
              lg_d    = 1'b0;
            end else begin
              dc_d = dc_q + DC_ONE;
            end
          end
          ST_HELD: begin
            if (!s) begin
              state_d = ST_DEB_R;
              dc_d    = DC_ONE;
            end else if (hc_q == HC_LONG) begin
              state_d = ST_LONG;
              long_d  = 1'b1;
              hc_d    = '0;
              lg_d    = 1'b1;
            end else begin
              hc_d = hc_q + HC_ONE;
            end
          end
          ST_LONG: begin
            if (!s) begin
              state_d = ST_DEB_R;
              dc_d    = DC_ONE;
            end else if (hc_q == HC_REP) begin
              rep_d = REP_EN;
              hc_d  = '0;
            end else begin
              hc_d = hc_q + HC_ONE;
            end
          end
          ST_DEB_R: begin
            // A bounce back to high resumes the hold timing where it left off.
            if (s) begin
              state_d = lg_q ? ST_LONG : ST_HELD;
            end else if (dc_q == DC_LAST) begin
              state_d = ST_IDLE;
              short_d = !lg_q;
            end else begin
              dc_d = dc_q + DC_ONE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            dc_d    = '0;
            hc_d    = '0;
            lg_d    = 1'b0;
          end
        endcase
      end

      held_d = (state_d == ST_HELD) || (state_d == ST_LONG) || (state_d == ST_DEB_R);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        dc_q    <= '0;
        hc_q    <= '0;
        lg_q    <= 1'b0;
        srv_q   <= 1'b0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        dc_q    <= dc_d;
        hc_q    <= hc_d;
        lg_q    <= lg_d;
        srv_q   <= srv_d;
        short_q <= short_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
        held_q  <= held_d;
      end
    end

    assign srv_o[g]   = srv_q;
    assign short_o[g] = short_q;
    assign long_o[g]  = long_q;
    assign rep_o[g]   = rep_q;
    assign held_o[g]  = held_q;
  end

endmodule

// File: tb/tb_drv_btn_mc.sv
module tb_drv_btn_mc;

  localparam int NR_CH = 4;
  localparam int DEB   = 4;
  localparam int LONGC = 20;
  localparam int REPC  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [NR_CH-1:0] btn = '0;
  logic [NR_CH-1:0] srv_o, short_o, long_o, rep_o, held_o;
  logic [NR_CH-1:0] nr_srv, nr_short, nr_long, nr_rep, nr_held;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  drv_btn_mc #(.NR_CH(NR_CH), .DEB_CYC(DEB), .LONG_CYC(LONGC), .REP_CYC(REPC), .REP_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .btn_i(btn),
    .srv_o(srv_o), .short_o(short_o), .long_o(long_o), .rep_o(rep_o), .held_o(held_o)
  );

  drv_btn_mc #(.NR_CH(NR_CH), .DEB_CYC(DEB), .LONG_CYC(LONGC), .REP_CYC(REPC), .REP_EN(1'b0)) u_norep (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .btn_i(btn),
    .srv_o(nr_srv), .short_o(nr_short), .long_o(nr_long), .rep_o(nr_rep), .held_o(nr_held)
  );

  always #5 clk = ~clk;

  // Reference model: run-length view of the synchronised level per channel.
  int m_s1[NR_CH], m_s2[NR_CH], hi_run[NR_CH], lo_run[NR_CH], hold_t[NR_CH];
  int m_held[NR_CH], m_lg[NR_CH];
  logic [NR_CH-1:0] exp_srv, exp_short, exp_long, exp_rep, exp_held;

  task automatic model_reset();
    for (int c = 0; c < NR_CH; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; hi_run[c] = 0; lo_run[c] = 0;
      hold_t[c] = 0; m_held[c] = 0; m_lg[c] = 0;
    end
    exp_srv = '0; exp_short = '0; exp_long = '0; exp_rep = '0; exp_held = '0;
  endtask

  task automatic model_step();
    int s;
    for (int c = 0; c < NR_CH; c++) begin
      s = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = btn[c] ? 1 : 0;
      exp_srv[c] = 1'b0; exp_short[c] = 1'b0; exp_long[c] = 1'b0; exp_rep[c] = 1'b0;
      if (!enable) begin
        hi_run[c] = 0; lo_run[c] = 0; hold_t[c] = 0; m_held[c] = 0; m_lg[c] = 0;
      end else if (m_held[c] == 0) begin
        if (s != 0) begin
          hi_run[c]++;
          if (hi_run[c] == DEB) begin
            m_held[c] = 1; exp_srv[c] = 1'b1; hold_t[c] = 0; m_lg[c] = 0;
            hi_run[c] = 0; lo_run[c] = 0;
          end
        end else begin
          hi_run[c] = 0;
        end
      end else begin
        if (s != 0) begin
          if (lo_run[c] > 0) begin
            lo_run[c] = 0;
          end else begin
            hold_t[c]++;
            if (m_lg[c] == 0 && hold_t[c] == LONGC) begin
              exp_long[c] = 1'b1; m_lg[c] = 1; hold_t[c] = 0;
            end else if (m_lg[c] != 0 && hold_t[c] == REPC) begin
              exp_rep[c] = 1'b1; hold_t[c] = 0;
            end
          end
        end else begin
          lo_run[c]++;
          if (lo_run[c] == DEB) begin
            m_held[c] = 0;
            if (m_lg[c] == 0) exp_short[c] = 1'b1;
            lo_run[c] = 0; m_lg[c] = 0; hold_t[c] = 0;
          end
        end
      end
      exp_held[c] = (m_held[c] != 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({srv_o, short_o, long_o, rep_o, held_o, nr_held} !== '0) begin
      n_fail++;
      $display("FAIL reset.immediate actual=%h required=0", {srv_o, short_o, long_o, rep_o, held_o, nr_held});
    end
    btn = '1; enable = 1'b1;
    repeat (3) step();
    n_chk++;
    if ({srv_o, short_o, long_o, rep_o, held_o} !== '0) begin
      n_fail++;
      $display("FAIL reset.held_in_reset actual=%h required=0", {srv_o, short_o, long_o, rep_o, held_o});
    end
    btn = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (6) step();
    n_chk++;
    if ({srv_o, short_o, long_o, rep_o, held_o} !== '0) begin
      n_fail++;
      $display("FAIL reset.idle_after actual=%h required=0", {srv_o, short_o, long_o, rep_o, held_o});
    end
  endtask

  task automatic test_short_press();
    int k, srv_at, short_at, n_srv, n_short, n_lr, n_held;
    srv_at = -1; short_at = -1; n_srv = 0; n_short = 0; n_lr = 0; n_held = 0;
    k = cyc + 1;
    btn[0] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i == 10) btn[0] = 1'b0;
      step();
      if (srv_o[0]) begin n_srv++; srv_at = cyc; end
      if (short_o[0]) begin n_short++; short_at = cyc; end
      if (long_o[0] || rep_o[0]) n_lr++;
      if (held_o[0]) n_held++;
    end
    n_chk++; if (srv_at - k !== 5) begin n_fail++; $display("FAIL short.srv_at actual=%0d required=5", srv_at - k); end
    n_chk++; if (n_srv !== 1) begin n_fail++; $display("FAIL short.srv_count actual=%0d required=1", n_srv); end
    n_chk++; if (short_at - k !== 15) begin n_fail++; $display("FAIL short.short_at actual=%0d required=15", short_at - k); end
    n_chk++; if (n_short !== 1) begin n_fail++; $display("FAIL short.short_count actual=%0d required=1", n_short); end
    n_chk++; if (n_lr !== 0) begin n_fail++; $display("FAIL short.no_long_rep actual=%0d required=0", n_lr); end
    n_chk++; if (n_held !== 10) begin n_fail++; $display("FAIL short.held_cycles actual=%0d required=10", n_held); end
  endtask

  task automatic test_long_press();
    int k, srv_at, long_at, rep_first, rep_last, n_rep, n_short, fall_at, nr_long_at, nr_reps;
    logic was_held;
    srv_at = -1; long_at = -1; rep_first = -1; rep_last = -1; n_rep = 0; n_short = 0;
    fall_at = -1; nr_long_at = -1; nr_reps = 0; was_held = 1'b0;
    k = cyc + 1;
    btn[1] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 40) btn[1] = 1'b0;
      step();
      if (srv_o[1]) srv_at = cyc;
      if (long_o[1]) long_at = cyc;
      if (rep_o[1]) begin
        n_rep++;
        if (rep_first < 0) rep_first = cyc;
        rep_last = cyc;
      end
      if (short_o[1]) n_short++;
      if (held_o[1]) was_held = 1'b1;
      else if (was_held && fall_at < 0) fall_at = cyc;
      if (nr_long[1]) nr_long_at = cyc;
      if (nr_rep != '0) nr_reps++;
    end
    n_chk++; if (srv_at - k !== 5) begin n_fail++; $display("FAIL long.srv_at actual=%0d required=5", srv_at - k); end
    n_chk++; if (long_at - k !== 25) begin n_fail++; $display("FAIL long.long_at actual=%0d required=25", long_at - k); end
    n_chk++; if (n_rep !== 2) begin n_fail++; $display("FAIL long.rep_count actual=%0d required=2", n_rep); end
    n_chk++; if (rep_first - k !== 33) begin n_fail++; $display("FAIL long.rep_first actual=%0d required=33", rep_first - k); end
    n_chk++; if (rep_last - k !== 41) begin n_fail++; $display("FAIL long.rep_last actual=%0d required=41", rep_last - k); end
    n_chk++; if (n_short !== 0) begin n_fail++; $display("FAIL long.no_short actual=%0d required=0", n_short); end
    n_chk++; if (fall_at - k !== 45) begin n_fail++; $display("FAIL long.held_fall actual=%0d required=45", fall_at - k); end
    n_chk++; if (nr_long_at - k !== 25) begin n_fail++; $display("FAIL norep.long_at actual=%0d required=25", nr_long_at - k); end
    n_chk++; if (nr_reps !== 0) begin n_fail++; $display("FAIL norep.rep_count actual=%0d required=0", nr_reps); end
  endtask

  task automatic test_debounce_threshold();
    int k, n_any, srv_at, short_at, n_short;
    n_any = 0; srv_at = -1; short_at = -1; n_short = 0;
    btn[2] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) btn[2] = 1'b0;
      step();
      if (srv_o[2] || short_o[2] || long_o[2] || rep_o[2] || held_o[2]) n_any++;
    end
    n_chk++; if (n_any !== 0) begin n_fail++; $display("FAIL deb.reject_3 actual=%0d required=0", n_any); end
    k = cyc + 1;
    btn[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) btn[2] = 1'b0;
      step();
      if (srv_o[2]) srv_at = cyc;
      if (short_o[2]) begin n_short++; short_at = cyc; end
    end
    n_chk++; if (srv_at - k !== 5) begin n_fail++; $display("FAIL deb.accept_4_srv actual=%0d required=5", srv_at - k); end
    n_chk++; if (n_short !== 1) begin n_fail++; $display("FAIL deb.short_count actual=%0d required=1", n_short); end
    n_chk++; if (short_at - k !== 9) begin n_fail++; $display("FAIL deb.short_at actual=%0d required=9", short_at - k); end
  endtask

  task automatic test_glitch();
    int k, n_srv, n_short, long_at, n_held, fall_at;
    logic was_held;
    n_srv = 0; n_short = 0; long_at = -1; n_held = 0; fall_at = -1; was_held = 1'b0;
    k = cyc + 1;
    for (int i = 0; i < 45; i++) begin
      btn[3] = (i < 30) && (i != 10) && (i != 11);
      step();
      if (srv_o[3]) n_srv++;
      if (short_o[3]) n_short++;
      if (long_o[3]) long_at = cyc;
      if (held_o[3]) begin was_held = 1'b1; n_held++; end
      else if (was_held && fall_at < 0) fall_at = cyc;
    end
    n_chk++; if (n_srv !== 1) begin n_fail++; $display("FAIL glitch.srv_count actual=%0d required=1", n_srv); end
    n_chk++; if (n_short !== 0) begin n_fail++; $display("FAIL glitch.short_count actual=%0d required=0", n_short); end
    n_chk++; if (long_at - k !== 28) begin n_fail++; $display("FAIL glitch.long_at actual=%0d required=28", long_at - k); end
    n_chk++; if (n_held !== 30) begin n_fail++; $display("FAIL glitch.held_cycles actual=%0d required=30", n_held); end
    n_chk++; if (fall_at - k !== 35) begin n_fail++; $display("FAIL glitch.held_fall actual=%0d required=35", fall_at - k); end
  endtask

  task automatic test_simultaneous();
    int k, n_ev;
    logic [NR_CH-1:0] srv_vec, short_vec;
    n_ev = 0; srv_vec = '0; short_vec = '0;
    k = cyc + 1;
    btn = '1;
    for (int i = 0; i < 15; i++) begin
      if (i == 6) btn = '0;
      step();
      if (srv_o != '0) n_ev++;
      if (cyc == k + 5) srv_vec = srv_o;
      if (cyc == k + 11) short_vec = short_o;
    end
    n_chk++; if (srv_vec !== 4'hF) begin n_fail++; $display("FAIL simul.srv_vec actual=%h required=f", srv_vec); end
    n_chk++; if (n_ev !== 1) begin n_fail++; $display("FAIL simul.srv_events actual=%0d required=1", n_ev); end
    n_chk++; if (short_vec !== 4'hF) begin n_fail++; $display("FAIL simul.short_vec actual=%h required=f", short_vec); end
  endtask

  task automatic test_enable_abort();
    int e2, srv_at, n_short, n_short2;
    srv_at = -1; n_short = 0; n_short2 = 0;
    btn[0] = 1'b1;
    repeat (12) step();
    enable = 1'b0;
    step();
    n_chk++;
    if ({srv_o, short_o, long_o, rep_o, held_o} !== '0) begin
      n_fail++;
      $display("FAIL enable.abort_outputs actual=%h required=0", {srv_o, short_o, long_o, rep_o, held_o});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (short_o[0]) n_short++;
    end
    enable = 1'b1;
    e2 = cyc;
    for (int i = 0; i < 10; i++) begin
      step();
      if (srv_o[0] && srv_at < 0) srv_at = cyc;
      if (short_o[0]) n_short++;
    end
    n_chk++; if (srv_at - e2 !== 4) begin n_fail++; $display("FAIL enable.resume_srv actual=%0d required=4", srv_at - e2); end
    n_chk++; if (n_short !== 0) begin n_fail++; $display("FAIL enable.no_short actual=%0d required=0", n_short); end
    btn[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (short_o[0]) n_short2++;
    end
    n_chk++; if (n_short2 !== 1) begin n_fail++; $display("FAIL enable.release_short actual=%0d required=1", n_short2); end
  endtask

  task automatic test_async_reset();
    int k2, srv_at;
    srv_at = -1;
    btn[1] = 1'b1;
    repeat (30) step();
    n_chk++; if (held_o[1] !== 1'b1) begin n_fail++; $display("FAIL areset.pre_held actual=%b required=1", held_o[1]); end
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if ({srv_o, short_o, long_o, rep_o, held_o, nr_held} !== '0) begin
      n_fail++;
      $display("FAIL areset.immediate actual=%h required=0", {srv_o, short_o, long_o, rep_o, held_o, nr_held});
    end
    repeat (2) step();
    rst = 1'b0;
    k2 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (srv_o[1]) srv_at = cyc;
    end
    n_chk++; if (srv_at - k2 !== 5) begin n_fail++; $display("FAIL areset.srv_after actual=%0d required=5", srv_at - k2); end
    btn[1] = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_random();
    int runlen[NR_CH];
    int en_off;
    en_off = 0;
    for (int c = 0; c < NR_CH; c++) runlen[c] = $urandom_range(1, 30);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NR_CH; c++) begin
        if (runlen[c] == 0) begin
          btn[c] = ~btn[c];
          runlen[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB) : $urandom_range(1, 45);
        end else begin
          runlen[c]--;
        end
      end
      if (en_off == 0 && $urandom_range(0, 299) == 0) en_off = $urandom_range(1, 5);
      enable = (en_off == 0);
      if (en_off > 0) en_off--;
      step();
      n_chk++;
      if ({srv_o, short_o, long_o, rep_o, held_o} !== {exp_srv, exp_short, exp_long, exp_rep, exp_held}) begin
        n_fail++;
        $display("FAIL random.outputs cyc=%0d actual=%h required=%h", cyc,
                 {srv_o, short_o, long_o, rep_o, held_o}, {exp_srv, exp_short, exp_long, exp_rep, exp_held});
      end
      n_chk++;
      if ({nr_srv, nr_short, nr_long, nr_rep, nr_held} !== {exp_srv, exp_short, exp_long, 4'b0000, exp_held}) begin
        n_fail++;
        $display("FAIL random.norep_outputs cyc=%0d actual=%h required=%h", cyc,
                 {nr_srv, nr_short, nr_long, nr_rep, nr_held}, {exp_srv, exp_short, exp_long, 4'b0000, exp_held});
      end
    end
    enable = 1'b1;
    btn = '0;
    repeat (12) step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short_press();
    test_long_press();
    test_debounce_threshold();
    test_glitch();
    test_simultaneous();
    test_enable_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/drv_btn_mc.md
# drv_btn_mc

Multi-channel button driver, the parametrised successor of `drv_btn`. It synchronises and debounces `NR_CH` independent raw button inputs. Each press is classified as a short press or a long press, and auto-repeat pulses are generated while a long press is held. It sits between the board push-buttons and the control logic (counters, mode selects) and replaces per-button `drv_btn` instances.

## Interface
- `NR_CH`, default 4: number of independent button channels.
- `DEB_CYC`, default 4: consecutive stable synchronised samples needed to accept a press or a release (min 2).
- `LONG_CYC`, default 20: cycles in HELD, counted from the press pulse, before the press is declared long (min 2).
- `REP_CYC`, default 8: auto-repeat period while long-held (min 1).
- `REP_EN`, default 1: 1 enables auto-repeat pulses, 0 suppresses `rep_o`.
- `clk_i`  in  1: clock; all state updates on its rising edge.
- `rst_i`  in  1: asynchronous, active-high reset.
- `enable_i`  in  1: 0 synchronously forces every channel to IDLE.
- `btn_i`  in  NR_CH: raw, asynchronous button levels.
- `srv_o`  out  NR_CH: one-cycle pulse on an accepted press.
- `short_o`  out  NR_CH: one-cycle pulse on release of a press that never became long.
- `long_o`  out  NR_CH: one-cycle pulse when a press becomes long.
- `rep_o`  out  NR_CH: one-cycle auto-repeat pulses during a long press.
- `held_o`  out  NR_CH: level, 1 while the channel is in HELD, LONG or DEB_R.

## Operation
- **Channels:** fully independent; simultaneous events on different channels never interact.
- **Synchroniser:** per channel, a 2-flop synchroniser produces `s`. It keeps running when `enable_i`=0.
- **Per-channel state:**
  - FSM: IDLE, DEB_P, HELD, LONG, DEB_R.
  - Debounce counter `dc`.
  - Hold/repeat counter `hc`, width `$clog2(max(LONG_CYC,REP_CYC))+1`.
  - Flag `lg`.
- **IDLE:** `s`=1 -> DEB_P, `dc`=1.
- **DEB_P:**
  - `s`=0 -> IDLE (glitch rejected).
  - `s`=1 and `dc`==DEB_CYC-1 -> HELD, `srv_o` pulse, `hc`=0, `lg`=0.
  - Otherwise `dc`++.
- **HELD:**
  - `s`=0 -> DEB_R, `dc`=1; `hc` frozen.
  - `s`=1 and `hc`==LONG_CYC-1 -> LONG, `long_o` pulse, `hc`=0, `lg`=1.
  - Otherwise `hc`++.
- **LONG:**
  - `s`=0 -> DEB_R, `dc`=1; `hc` frozen.
  - `hc`==REP_CYC-1 -> `rep_o` pulse (if REP_EN), `hc`=0.
  - Otherwise `hc`++.
- **DEB_R:**
  - `s`=1 -> return to HELD if `lg`=0, LONG if `lg`=1; `hc` resumes from its frozen value; no output pulse.
  - `s`=0 and `dc`==DEB_CYC-1 -> IDLE; `short_o` pulse if `lg`=0, none if `lg`=1.
  - Otherwise `dc`++.
- **`enable_i`=0:** on the next edge all FSMs go to IDLE, counters and `lg` clear, all outputs 0. No `short_o` is emitted for an aborted press.
- **Per-press pulse rules:**
  - Exactly one `srv_o` per accepted press.
  - Either exactly one `short_o`, or exactly one `long_o` followed by zero or more `rep_o`.

## Timing
- **Reset:** all outputs, FSMs (IDLE), counters, flags and synchroniser flops are 0 immediately on `rst_i`. The first evaluation happens on the first edge after `rst_i` falls.
- **All outputs are registered.** Edge k is the first edge sampling `btn_i`=1.
- **Press latency:** `srv_o` is high in the cycle after edge k+DEB_CYC+1.
  - A stable high of exactly DEB_CYC cycles is accepted.
  - A stable high of DEB_CYC-1 cycles is rejected.
- **Long press:** `long_o` follows exactly LONG_CYC edges after the `srv_o` edge, provided `s` stayed 1.
- **Auto-repeat:** `rep_o` pulses follow every REP_CYC edges after the `long_o` edge.
- **Release latency:** `short_o` is high after edge r+DEB_CYC+1, where r is the first edge sampling `btn_i`=0.
- **Held level:** `held_o` rises together with `srv_o` and falls together with the release pulse (or with the IDLE entry for a long press).
- **Mid-release glitch:** a glitch shorter than DEB_CYC cycles during release produces no pulse, and `held_o` stays 1.

## Test plan
Defaults apply unless stated: NR_CH=4, DEB_CYC=4, LONG_CYC=20, REP_CYC=8, REP_EN=1.
- **Short press:** ch0 high 10 cycles from edge k.
  - `srv_o[0]` at k+5.
  - `short_o[0]` at k+15.
  - `held_o[0]` high between them.
  - No `long_o`/`rep_o`.
- **Long press:** ch1 high 40 cycles from edge k.
  - `srv_o[1]` at k+5, `long_o[1]` at k+25.
  - `rep_o[1]` at k+33 and k+41.
  - No `short_o[1]`; `held_o[1]` falls at k+45.
- **Debounce threshold:** ch2 high 3 cycles -> no outputs at all. Then high 4 cycles -> `srv_o[2]` at k+5 and one `short_o[2]`.
- **Glitches:**
  - ch3 held 30 cycles with a 2-cycle low glitch at cycle 10 -> one `srv_o`, no `short_o` during the glitch, `held_o` continuous.
  - All 4 channels pressed on the same edge -> four simultaneous `srv_o` pulses.
- **Enable abort:** `enable_i` dropped while ch0 held -> next edge all outputs 0, no `short_o`. Re-enable with button still high -> new `srv_o[0]` 4 edges later (DEB_CYC).
- **Async reset:** `rst_i` pulsed asynchronously mid-LONG on ch1 -> all outputs 0 immediately, no edge required. After release with button still high -> `srv_o[1]` at edge k+5 counted from the first post-reset edge. REP_EN=0 rerun of the long-press scenario -> no `rep_o`.
